// File: rtl/polling_ctrl.sv
// polling_ctrl: LTSSM Polling sub-state sequencer.
// Drives the ordered-set transmitter (TS1, TS2 or the compliance pattern),
// qualifies received TS1/TS2 per detected lane, and reports either
// completion (go to CONFIGURATION) or timeout (go to DETECT).
module polling_ctrl #(
  parameter int NUM_LANES      = 1,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int TS1_MIN_TX     = 1024,
  parameter int RX_TS_REQ      = 8,
  parameter int TS2_TX_AFTER   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enter_i,
  input  logic [NUM_LANES-1:0] lane_detected_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  input  logic                 rx_compliance_i,
  input  logic                 os_tx_ready_i,
  output logic                 os_tx_valid_o,
  output logic [1:0]           os_tx_type_o,
  output logic [NUM_LANES-1:0] os_tx_lane_en_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [1:0]           state_o
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ACTIVE     = 2'd1;
  localparam logic [1:0] ST_CONFIG     = 2'd2;
  localparam logic [1:0] ST_COMPLIANCE = 2'd3;

  localparam logic [1:0] OS_TS1   = 2'd0;
  localparam logic [1:0] OS_TS2   = 2'd1;
  localparam logic [1:0] OS_COMPL = 2'd2;

  localparam int TX_MAX = (TS1_MIN_TX > TS2_TX_AFTER) ? TS1_MIN_TX : TS2_TX_AFTER;
  localparam int TXW    = $clog2(TX_MAX + 1);
  localparam int RXW    = $clog2(RX_TS_REQ + 1);
  localparam int TMW    = $clog2(2 * TIMEOUT_CYCLES);

  localparam logic [TXW-1:0] TX_TS1_LIM    = TXW'(TS1_MIN_TX);
  localparam logic [TXW-1:0] TX_TS2_LIM    = TXW'(TS2_TX_AFTER);
  localparam logic [RXW-1:0] RX_LIM        = RXW'(RX_TS_REQ);
  localparam logic [TMW-1:0] TM_ACTIVE_END = TMW'(TIMEOUT_CYCLES - 1);
  localparam logic [TMW-1:0] TM_CONFIG_END = TMW'(2 * TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [NUM_LANES-1:0] mask_q;
  logic [TXW-1:0]       tx_cnt_q;
  logic [RXW-1:0]       rx_cnt_q [NUM_LANES];
  logic                 rx2_seen_q;
  logic [TMW-1:0]       timer_q;
  logic                 timer_hit_q;

  logic [NUM_LANES-1:0] rx_full;
  logic [NUM_LANES-1:0] ts1_m;
  logic [NUM_LANES-1:0] ts2_m;
  logic                 all_full;
  logic                 any_full;
  logic                 tx_hs;
  logic                 latch_mask;
  logic                 restart;
  logic                 go_done;
  logic                 go_timeout;
  logic                 leave;

  assign state_o         = state_q;
  assign os_tx_lane_en_o = mask_q;

  // Unmasked lanes never count and never block an "all lanes" test.
  assign ts1_m      = rx_ts1_i & mask_q;
  assign ts2_m      = rx_ts2_i & mask_q;
  assign all_full   = &(rx_full | ~mask_q);
  assign any_full   = |(rx_full & mask_q);
  assign tx_hs      = os_tx_valid_o & os_tx_ready_i;
  assign latch_mask = enter_i & (|lane_detected_i);
  assign leave      = (state_d != state_q) | restart;

  // Per-lane flag: this lane has seen the required run of qualifying sets.
  always_comb begin
    rx_full = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rx_full[i] = (rx_cnt_q[i] == RX_LIM);
    end
  end

  // Exit decisions; re-entry beats everything, then the per-state checks.
  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    go_done    = 1'b0;
    go_timeout = 1'b0;
    if (enter_i) begin
      if (|lane_detected_i) begin
        state_d = ST_ACTIVE;
        restart = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        go_timeout = 1'b1;
      end
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (rx_compliance_i) begin
            state_d = ST_COMPLIANCE;
          end else if ((tx_cnt_q == TX_TS1_LIM) && all_full) begin
            state_d = ST_CONFIG;
          end else if (timer_hit_q) begin
            if ((tx_cnt_q == TX_TS1_LIM) && any_full) begin
              state_d = ST_CONFIG;
            end else begin
              state_d    = ST_IDLE;
              go_timeout = 1'b1;
            end
          end
        end
        ST_CONFIG: begin
          if (all_full && (tx_cnt_q == TX_TS2_LIM)) begin
            state_d = ST_IDLE;
            go_done = 1'b1;
          end else if (timer_hit_q) begin
            state_d    = ST_IDLE;
            go_timeout = 1'b1;
          end
        end
        ST_COMPLIANCE: begin
          if (|ts1_m) begin
            state_d = ST_ACTIVE;
            restart = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, timer and registered output decodes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      tx_cnt_q      <= '0;
      rx2_seen_q    <= 1'b0;
      timer_q       <= '0;
      timer_hit_q   <= 1'b0;
      os_tx_valid_o <= 1'b0;
      os_tx_type_o  <= OS_TS1;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rx_cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      done_o        <= go_done;
      timeout_o     <= go_timeout;
      os_tx_valid_o <= (state_d != ST_IDLE);
      case (state_d)
        ST_CONFIG:     os_tx_type_o <= OS_TS2;
        ST_COMPLIANCE: os_tx_type_o <= OS_COMPL;
        default:       os_tx_type_o <= OS_TS1;
      endcase
      if (latch_mask) begin
        mask_q <= lane_detected_i;
      end
      if (leave) begin
        tx_cnt_q    <= '0;
        rx2_seen_q  <= 1'b0;
        timer_q     <= '0;
        timer_hit_q <= 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
          rx_cnt_q[i] <= '0;
        end
      end else begin
        if ((state_q == ST_ACTIVE) || (state_q == ST_CONFIG)) begin
          timer_q <= timer_q + 1'b1;
        end
        // Expiry is registered so the exit decision sees a stable flag.
        timer_hit_q <= ((state_q == ST_ACTIVE) && (timer_q == TM_ACTIVE_END)) ||
                       ((state_q == ST_CONFIG) && (timer_q == TM_CONFIG_END));
        case (state_q)
          ST_ACTIVE: begin
            if (tx_hs && (tx_cnt_q != TX_TS1_LIM)) begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
              if ((ts1_m[i] | ts2_m[i]) && !rx_full[i]) begin
                rx_cnt_q[i] <= rx_cnt_q[i] + 1'b1;
              end
            end
          end
          ST_CONFIG: begin
            if (|ts2_m) begin
              rx2_seen_q <= 1'b1;
            end
            if (tx_hs && (rx2_seen_q || (|ts2_m)) && (tx_cnt_q != TX_TS2_LIM)) begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
              if (ts2_m[i]) begin
                if (!rx_full[i]) begin
                  rx_cnt_q[i] <= rx_cnt_q[i] + 1'b1;
                end
              end else if (ts1_m[i]) begin
                rx_cnt_q[i] <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_polling_ctrl.sv
// tb_polling_ctrl: randomized scoreboard bench for polling_ctrl.
// A behavioural model predicts every output change or pulse; a monitor
// compares each observed change against the queued prediction.
module tb_polling_ctrl;

  localparam int NL    = 2;
  localparam int TMO   = 200;
  localparam int TS1N  = 16;
  localparam int RXREQ = 8;
  localparam int TS2N  = 16;

  localparam int P_IDLE   = 0;
  localparam int P_ACTIVE = 1;
  localparam int P_CONFIG = 2;
  localparam int P_COMPL  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enter;
  logic [NL-1:0] det;
  logic [NL-1:0] ts1;
  logic [NL-1:0] ts2;
  logic          comp;
  logic          ready;
  logic          os_tx_valid;
  logic [1:0]    os_tx_type;
  logic [NL-1:0] os_tx_lane_en;
  logic          done;
  logic          timeout;
  logic [1:0]    state;

  polling_ctrl #(
    .NUM_LANES(NL), .TIMEOUT_CYCLES(TMO), .TS1_MIN_TX(TS1N),
    .RX_TS_REQ(RXREQ), .TS2_TX_AFTER(TS2N)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enter_i(enter), .lane_detected_i(det),
    .rx_ts1_i(ts1), .rx_ts2_i(ts2), .rx_compliance_i(comp),
    .os_tx_ready_i(ready), .os_tx_valid_o(os_tx_valid),
    .os_tx_type_o(os_tx_type), .os_tx_lane_en_o(os_tx_lane_en),
    .done_o(done), .timeout_o(timeout), .state_o(state)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to timestamp predictions and observations.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int st;
    int vld;
    int ty;
    int lanes;
    int dn;
    int to;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: abstract phase, plain integer counts, age in phase.
  int            m_ph = P_IDLE;
  logic [NL-1:0] m_mask = '0;
  int            m_tx = 0;
  int            m_rx [NL];
  bit            m_seen = 0;
  int            m_age = 0;
  int            e_st = 0, e_vld = 0, e_ty = 0, e_lanes = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit allLanesDone();
    for (int l = 0; l < NL; l++) begin
      if (m_mask[l] && (m_rx[l] < RXREQ)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit anyLaneDone();
    for (int l = 0; l < NL; l++) begin
      if (m_mask[l] && (m_rx[l] >= RXREQ)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NL-1:0] randomLanes(input int pct);
    logic [NL-1:0] r;
    for (int l = 0; l < NL; l++) r[l] = ($urandom_range(0, 99) < pct);
    return r;
  endfunction

  task automatic clearModel();
    m_tx   = 0;
    m_seen = 0;
    m_age  = 0;
    for (int l = 0; l < NL; l++) m_rx[l] = 0;
  endtask

  // Predict the outputs of the next cycle from this cycle's inputs.
  task automatic modelStep();
    int  nph;
    int  dn;
    int  to;
    bit  restart;
    bit  hs;
    bit  new_ts2;
    int  st, vld, ty, lanes;
    ev_t e;
    nph = m_ph; dn = 0; to = 0; restart = 0;
    if (rst) begin
      m_ph   = P_IDLE;
      m_mask = '0;
      clearModel();
    end else begin
      if (enter) begin
        if (det != '0) begin nph = P_ACTIVE; restart = 1; end
        else begin nph = P_IDLE; to = 1; end
      end else if (m_ph == P_ACTIVE) begin
        if (comp) nph = P_COMPL;
        else if (m_tx >= TS1N && allLanesDone()) nph = P_CONFIG;
        else if (m_age == TMO) begin
          if (m_tx >= TS1N && anyLaneDone()) nph = P_CONFIG;
          else begin nph = P_IDLE; to = 1; end
        end
      end else if (m_ph == P_CONFIG) begin
        if (allLanesDone() && m_tx >= TS2N) begin nph = P_IDLE; dn = 1; end
        else if (m_age == 2 * TMO) begin nph = P_IDLE; to = 1; end
      end else if (m_ph == P_COMPL) begin
        if ((ts1 & m_mask) != '0) begin nph = P_ACTIVE; restart = 1; end
      end
      if (nph != m_ph || restart) begin
        if (enter && det != '0) m_mask = det;
        m_ph = nph;
        clearModel();
      end else begin
        m_age++;
        hs = (m_ph != P_IDLE) && ready;
        if (m_ph == P_ACTIVE) begin
          if (hs) m_tx = sat(m_tx + 1, TS1N);
          for (int l = 0; l < NL; l++)
            if (m_mask[l] && (ts1[l] || ts2[l])) m_rx[l] = sat(m_rx[l] + 1, RXREQ);
        end else if (m_ph == P_CONFIG) begin
          new_ts2 = ((ts2 & m_mask) != '0);
          if ((m_seen || new_ts2) && hs) m_tx = sat(m_tx + 1, TS2N);
          if (new_ts2) m_seen = 1;
          for (int l = 0; l < NL; l++) begin
            if (m_mask[l] && ts2[l]) m_rx[l] = sat(m_rx[l] + 1, RXREQ);
            else if (m_mask[l] && ts1[l]) m_rx[l] = 0;
          end
        end
      end
    end
    st    = m_ph;
    vld   = (m_ph != P_IDLE) ? 1 : 0;
    ty    = (m_ph == P_CONFIG) ? 1 : ((m_ph == P_COMPL) ? 2 : 0);
    lanes = int'(m_mask);
    if (st != e_st || vld != e_vld || ty != e_ty || lanes != e_lanes || dn != 0 || to != 0) begin
      e.at = cyc + 1; e.st = st; e.vld = vld; e.ty = ty; e.lanes = lanes; e.dn = dn; e.to = to;
      sb.push_back(e);
    end
    e_st = st; e_vld = vld; e_ty = ty; e_lanes = lanes;
  endtask

  // Drive one cycle of inputs, update the model, advance to the next cycle.
  task automatic applyStimulus(input logic r, input logic en, input logic [NL-1:0] d,
                               input logic [NL-1:0] t1, input logic [NL-1:0] t2,
                               input logic c, input logic rd);
    rst = r; enter = en; det = d; ts1 = t1; ts2 = t2; comp = c; ready = rd;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int k, input logic rd);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, '0, '0, '0, 0, rd);
  endtask

  task automatic idleWhile(input int ph, input int maxc);
    int n;
    n = 0;
    while (m_ph == ph && n < maxc) begin
      applyStimulus(0, 0, '0, '0, '0, 0, 1);
      n++;
    end
  endtask

  // Enter ACTIVE with both lanes and push both lanes into CONFIG.
  task automatic reachConfig();
    applyStimulus(0, 1, 2'b11, '0, '0, 0, 1);
    for (int i = 0; i < RXREQ; i++) applyStimulus(0, 0, '0, 2'b11, '0, 0, 1);
    idleWhile(P_ACTIVE, 300);
  endtask

  task automatic linkUp(input logic [NL-1:0] msk, input int pct, input int rdy_pct);
    int n;
    logic [NL-1:0] t1, t2;
    applyStimulus(0, 1, msk, '0, '0, 0, 1);
    n = 0;
    while (m_ph == P_ACTIVE && n < 400) begin
      applyStimulus(0, 0, '0, randomLanes(pct), randomLanes(5), 0, ($urandom_range(0, 99) < rdy_pct));
      n++;
    end
    n = 0;
    while (m_ph == P_CONFIG && n < 600) begin
      t2 = randomLanes(pct);
      t1 = randomLanes(4);
      applyStimulus(0, 0, '0, t1, t2, 0, ($urandom_range(0, 99) < rdy_pct));
      n++;
    end
    idleCycles(3, 1);
  endtask

  // Monitor: every output change or pulse must match the next prediction.
  initial begin : monitor
    bit  on;
    int  o_st, o_vld, o_ty, o_lanes;
    ev_t e;
    on = 0; o_st = 0; o_vld = 0; o_ty = 0; o_lanes = 0;
    forever begin
      @(negedge clk);
      if (!on && cyc >= 5) on = 1;
      if (on && (int'(state) != o_st || int'(os_tx_valid) != o_vld || int'(os_tx_type) != o_ty ||
                 int'(os_tx_lane_en) != o_lanes || done || timeout)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: output change at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("event_cycle", cyc, e.at);
          checkOutput("state_o", int'(state), e.st);
          checkOutput("os_tx_valid_o", int'(os_tx_valid), e.vld);
          checkOutput("os_tx_type_o", int'(os_tx_type), e.ty);
          checkOutput("os_tx_lane_en_o", int'(os_tx_lane_en), e.lanes);
          checkOutput("done_o", int'(done), e.dn);
          checkOutput("timeout_o", int'(timeout), e.to);
        end
        o_st = int'(state); o_vld = int'(os_tx_valid); o_ty = int'(os_tx_type);
        o_lanes = int'(os_tx_lane_en);
      end
    end
  end

  // Main stimulus sequence.
  initial begin : stimulus
    logic [NL-1:0] t2;
    rst = 1; enter = 0; det = '0; ts1 = '0; ts2 = '0; comp = 0; ready = 0;
    for (int l = 0; l < NL; l++) m_rx[l] = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, '0, '0, 0, 0);

    $display("[TB] reset state");
    checkOutput("reset_state_o", int'(state), 0);
    checkOutput("reset_valid", int'(os_tx_valid), 0);
    checkOutput("reset_type", int'(os_tx_type), 0);
    checkOutput("reset_lane_en", int'(os_tx_lane_en), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    idleCycles(3, 1);

    $display("[TB] normal link-up");
    applyStimulus(0, 1, 2'b11, '0, '0, 0, 1);
    for (int i = 0; i < RXREQ; i++) begin
      applyStimulus(0, 0, '0, 2'b11, '0, 0, 1);
      applyStimulus(0, 0, '0, '0, '0, 0, 1);
    end
    idleWhile(P_ACTIVE, 300);
    for (int i = 0; i < RXREQ; i++) applyStimulus(0, 0, '0, '0, 2'b11, 0, 1);
    idleWhile(P_CONFIG, 300);
    idleCycles(3, 1);

    $display("[TB] ACTIVE timeout");
    applyStimulus(0, 1, 2'b11, '0, '0, 0, 1);
    idleCycles(TMO + 5, 1);

    $display("[TB] partial-lane timeout");
    applyStimulus(0, 1, 2'b11, '0, '0, 0, 1);
    for (int i = 0; i < RXREQ; i++) applyStimulus(0, 0, '0, 2'b01, '0, 0, 1);
    idleWhile(P_ACTIVE, 300);
    idleWhile(P_CONFIG, 2 * TMO + 20);
    idleCycles(3, 1);

    $display("[TB] consecutive rule in CONFIG");
    reachConfig();
    for (int k = 0; k < 14; k++) begin
      t2 = '0;
      t2[0] = (k < 8);
      t2[1] = (k != 5);
      applyStimulus(0, 0, '0, (k == 5) ? 2'b10 : 2'b00, t2, 0, logic'(k % 2));
    end
    for (int k = 0; k < 200 && m_ph == P_CONFIG; k++) applyStimulus(0, 0, '0, '0, '0, 0, logic'(k % 2));
    idleCycles(3, 1);

    $display("[TB] compliance");
    applyStimulus(0, 1, 2'b01, '0, '0, 0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, (i < 7) ? 2'b01 : 2'b00, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, '0, 1, 1);
    applyStimulus(0, 0, '0, 2'b10, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 2'b01, 0, 1);
    idleCycles(3, 1);
    applyStimulus(0, 0, '0, 2'b01, '0, 0, 1);
    for (int i = 0; i < RXREQ; i++) applyStimulus(0, 0, '0, 2'b01, '0, 0, 1);
    idleWhile(P_ACTIVE, 300);
    for (int i = 0; i < RXREQ; i++) applyStimulus(0, 0, '0, '0, 2'b01, 0, 1);
    idleWhile(P_CONFIG, 300);
    idleCycles(3, 1);

    $display("[TB] empty mask and mid-CONFIG reset");
    applyStimulus(0, 1, 2'b00, '0, '0, 0, 1);
    idleCycles(3, 1);
    reachConfig();
    idleCycles(4, 1);
    applyStimulus(1, 0, '0, '0, '0, 0, 1);
    idleCycles(4, 1);

    $display("[TB] re-entry");
    applyStimulus(0, 1, 2'b11, '0, '0, 0, 1);
    idleCycles(10, 1);
    applyStimulus(0, 1, 2'b10, '0, '0, 1, 1);
    idleCycles(TMO + 5, 1);

    $display("[TB] randomized link-ups");
    for (int r = 0; r < 5; r++) begin
      linkUp(logic'($urandom_range(1, 3)), $urandom_range(30, 80), $urandom_range(50, 100));
    end

    $display("[TB] random soak");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 999) < 2), ($urandom_range(0, 999) < 5),
                    logic'($urandom_range(1, 3)), randomLanes(15), randomLanes(20),
                    ($urandom_range(0, 999) < 5), ($urandom_range(0, 99) < 70));
    end
    idleCycles(2 * TMO + 10, 1);

    checkOutput("scoreboard_pending", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
